// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer and synchronous flush.
// Optional saturating back-pressure counter enabled by PIPE_STAGE_STALLCNT_EN.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 224,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush
`ifdef PIPE_STAGE_STALLCNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Encoding chosen so out_valid is bit 0 and in_ready is the inverse of bit 1.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  if (DATA_W == 0 || CNT_W == 0) begin : g_param_check
    $error("pipe_stage_skid: DATA_W and CNT_W must be non-zero");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  // State and payload registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload movement; flush overrides everything
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid & in_ready & ~flush;
    out_fire = out_valid & out_ready & ~flush;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state and main registers
  always_comb begin
    in_ready  = ~state_q[1];
    out_valid = state_q[0];
    out_data  = main_q;
  end

`ifdef PIPE_STAGE_STALLCNT_EN
  // Saturating count of cycles a live payload waited on downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue-based model. Covers stall_cnt when PIPE_STAGE_STALLCNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 224;
`ifdef PIPE_STAGE_STALLCNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
`ifdef PIPE_STAGE_STALLCNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef PIPE_STAGE_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of held payloads (capacity two) plus stall counter
  logic [DATA_W-1:0] q[$];
  int                cnt_m = 0;
  int                cnt_max = (1 << CNT_W) - 1;

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic [DATA_W-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : '0;
    chk("in_ready", DATA_W'(in_ready), DATA_W'(q.size() < 2));
    chk("out_valid", DATA_W'(out_valid), DATA_W'(q.size() > 0));
    chk("out_data", out_data, exp_data);
`ifdef PIPE_STAGE_STALLCNT_EN
    chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(cnt_m));
`endif
  endtask

  // Drive one cycle of inputs, advance model across the edge, then check
  task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
    bit rdy_m, ov_m;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rdy_m = (q.size() < 2);
    ov_m  = (q.size() > 0);
    @(posedge clk);
    if (reset) begin
      if (ov_m && !ordy && !fl && cnt_m < cnt_max) cnt_m++;
      if (fl) begin
        q.delete();
      end else begin
        if (ov_m && ordy) void'(q.pop_front());
        if (iv && rdy_m) q.push_back(id);
      end
    end
    #1;
    chk_outputs();
  endtask

  initial begin
    logic [DATA_W-1:0] a, b, c, d;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state, and handshakes during reset are ignored
    #2;
    chk_outputs();
    step(1'b1, rnd_data(), 1'b1, 1'b0);
    reset = 1'b1;

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DATA_W'(i), 1'b1, 1'b0);
      chk("stream_data", out_data, DATA_W'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure fills skid; 3 held upstream until room appears
    step(1'b1, DATA_W'(1), 1'b1, 1'b0);
    step(1'b1, DATA_W'(2), 1'b0, 1'b0);
    chk("full_in_ready", DATA_W'(in_ready), '0);
    step(1'b1, DATA_W'(3), 1'b0, 1'b0);
    chk("full_hold_data", out_data, DATA_W'(1));
    step(1'b1, DATA_W'(3), 1'b1, 1'b0);
    chk("drain_second", out_data, DATA_W'(2));
    step(1'b1, DATA_W'(3), 1'b1, 1'b0);
    chk("drain_third", out_data, DATA_W'(3));
    step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous in/out in ONE replaces main
    a = rnd_data(); b = rnd_data(); c = rnd_data(); d = rnd_data();
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b1, 1'b0);
    chk("pass_through", out_data, b);

    // Flush in FULL discards held and incoming payloads
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b1);
    chk("flush_valid", DATA_W'(out_valid), '0);
    chk("flush_data", out_data, '0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    cnt_m = 0;
    chk_outputs();
    chk("async_rst_data", out_data, '0);
    @(negedge clk);
    reset = 1'b1;

`ifdef PIPE_STAGE_STALLCNT_EN
    // Saturating stall counter with CNT_W=2
    begin
      int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
      step(1'b1, rnd_data(), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        step(1'b0, '0, 1'b0, 1'b0);
        chk("stall_sat", DATA_W'(stall_cnt), DATA_W'(exp_cnt[i]));
      end
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_data(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
